// File: rtl/avg_alarm_monitor.sv
// Threshold alarm monitor for the 8-bit average stream: persistence/hysteresis FSM,
// min/max/count statistics and a held interrupt. Optional step-rate check: AVG_MON_RATE_EN.
module avg_alarm_monitor #(
    parameter logic [7:0]  HI_THR   = 8'd200,
    parameter logic [7:0]  LO_THR   = 8'd50,
    parameter logic [7:0]  HYST     = 8'd8,
    parameter int unsigned PERSIST  = 3,
    parameter logic [7:0]  RATE_MAX = 8'd32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  avg_i,
    input  logic        avg_valid_i,
    input  logic        clear_i,
    input  logic        irq_ack_i,
    output logic        alarm_hi_o,
    output logic        alarm_lo_o,
    output logic        irq_o,
    output logic [1:0]  event_code_o,
    output logic        overrun_o,
    output logic [7:0]  min_o,
    output logic [7:0]  max_o,
    output logic [15:0] sample_cnt_o,
    output logic        rate_err_o
);

    localparam logic [2:0] ST_NORMAL   = 3'd0;
    localparam logic [2:0] ST_PEND_HI  = 3'd1;
    localparam logic [2:0] ST_ALARM_HI = 3'd2;
    localparam logic [2:0] ST_PEND_LO  = 3'd3;
    localparam logic [2:0] ST_ALARM_LO = 3'd4;

    localparam logic [1:0] EVT_HI = 2'b01;
    localparam logic [1:0] EVT_LO = 2'b10;

    // Exit thresholds are widened to 9 bits so HYST cannot wrap them.
    localparam logic [8:0] HI_EXIT_C = {1'b0, HI_THR} - {1'b0, HYST};
    localparam logic [8:0] LO_EXIT_C = {1'b0, LO_THR} + {1'b0, HYST};
    localparam logic [3:0] PERSIST_C = 4'(PERSIST);
    localparam logic [2:0] HI_ENTRY_C = (PERSIST_C == 4'd1) ? ST_ALARM_HI : ST_PEND_HI;
    localparam logic [2:0] LO_ENTRY_C = (PERSIST_C == 4'd1) ? ST_ALARM_LO : ST_PEND_LO;

    logic [2:0]  state_r;
    logic [2:0]  state_nxt_s;
    logic [3:0]  pcnt_r;
    logic [3:0]  pcnt_nxt_s;
    logic        is_hi_s;
    logic        is_lo_s;
    logic        below_hi_exit_s;
    logic        above_lo_exit_s;
    logic        event_s;
    logic [1:0]  event_code_nxt_s;
    logic        alarm_hi_r;
    logic        alarm_lo_r;
    logic        irq_r;
    logic [1:0]  event_code_r;
    logic        overrun_r;
    logic [7:0]  min_r;
    logic [7:0]  max_r;
    logic [15:0] sample_cnt_r;

    assign is_hi_s         = (avg_i >= HI_THR);
    assign is_lo_s         = (avg_i <= LO_THR);
    assign below_hi_exit_s = ({1'b0, avg_i} < HI_EXIT_C);
    assign above_lo_exit_s = ({1'b0, avg_i} > LO_EXIT_C);

    // Next-state and persistence counter, evaluated only on valid samples
    always_comb begin
        state_nxt_s = state_r;
        pcnt_nxt_s  = pcnt_r;
        if (avg_valid_i) begin
            case (state_r)
                ST_NORMAL: begin
                    if (is_hi_s) begin
                        state_nxt_s = HI_ENTRY_C;
                        pcnt_nxt_s  = 4'd1;
                    end else if (is_lo_s) begin
                        state_nxt_s = LO_ENTRY_C;
                        pcnt_nxt_s  = 4'd1;
                    end else begin
                        state_nxt_s = ST_NORMAL;
                        pcnt_nxt_s  = 4'd0;
                    end
                end
                ST_PEND_HI: begin
                    if (is_hi_s) begin
                        pcnt_nxt_s  = pcnt_r + 4'd1;
                        state_nxt_s = ((pcnt_r + 4'd1) >= PERSIST_C) ? ST_ALARM_HI : ST_PEND_HI;
                    end else if (is_lo_s) begin
                        state_nxt_s = LO_ENTRY_C;
                        pcnt_nxt_s  = 4'd1;
                    end else begin
                        state_nxt_s = ST_NORMAL;
                        pcnt_nxt_s  = 4'd0;
                    end
                end
                ST_PEND_LO: begin
                    if (is_lo_s) begin
                        pcnt_nxt_s  = pcnt_r + 4'd1;
                        state_nxt_s = ((pcnt_r + 4'd1) >= PERSIST_C) ? ST_ALARM_LO : ST_PEND_LO;
                    end else if (is_hi_s) begin
                        state_nxt_s = HI_ENTRY_C;
                        pcnt_nxt_s  = 4'd1;
                    end else begin
                        state_nxt_s = ST_NORMAL;
                        pcnt_nxt_s  = 4'd0;
                    end
                end
                ST_ALARM_HI: begin
                    if (below_hi_exit_s && is_lo_s) begin
                        state_nxt_s = LO_ENTRY_C;
                        pcnt_nxt_s  = 4'd1;
                    end else if (below_hi_exit_s) begin
                        state_nxt_s = ST_NORMAL;
                        pcnt_nxt_s  = 4'd0;
                    end else begin
                        state_nxt_s = ST_ALARM_HI;
                        pcnt_nxt_s  = pcnt_r;
                    end
                end
                ST_ALARM_LO: begin
                    if (above_lo_exit_s && is_hi_s) begin
                        state_nxt_s = HI_ENTRY_C;
                        pcnt_nxt_s  = 4'd1;
                    end else if (above_lo_exit_s) begin
                        state_nxt_s = ST_NORMAL;
                        pcnt_nxt_s  = 4'd0;
                    end else begin
                        state_nxt_s = ST_ALARM_LO;
                        pcnt_nxt_s  = pcnt_r;
                    end
                end
                default: begin
                    state_nxt_s = ST_NORMAL;
                    pcnt_nxt_s  = 4'd0;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
            pcnt_nxt_s  = pcnt_r;
        end
    end

    // Alarm-entry event detection; leaving an alarm never raises one
    always_comb begin
        if (avg_valid_i && (state_nxt_s == ST_ALARM_HI) && (state_r != ST_ALARM_HI)) begin
            event_s          = 1'b1;
            event_code_nxt_s = EVT_HI;
        end else if (avg_valid_i && (state_nxt_s == ST_ALARM_LO) && (state_r != ST_ALARM_LO)) begin
            event_s          = 1'b1;
            event_code_nxt_s = EVT_LO;
        end else begin
            event_s          = 1'b0;
            event_code_nxt_s = 2'b00;
        end
    end

    // FSM state, alarm flags, interrupt and overrun registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r      <= ST_NORMAL;
            pcnt_r       <= 4'd0;
            alarm_hi_r   <= 1'b0;
            alarm_lo_r   <= 1'b0;
            irq_r        <= 1'b0;
            event_code_r <= 2'b00;
            overrun_r    <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            pcnt_r     <= pcnt_nxt_s;
            alarm_hi_r <= (state_nxt_s == ST_ALARM_HI);
            alarm_lo_r <= (state_nxt_s == ST_ALARM_LO);
            // A new event outranks a same-cycle ack, and that ack also suppresses overrun.
            if (event_s) begin
                irq_r        <= 1'b1;
                event_code_r <= event_code_nxt_s;
            end else if (irq_ack_i) begin
                irq_r <= 1'b0;
            end
            if (event_s && irq_r && !irq_ack_i) begin
                overrun_r <= 1'b1;
            end else if (clear_i) begin
                overrun_r <= 1'b0;
            end
        end
    end

    // Running min/max and saturating sample counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            min_r        <= 8'hFF;
            max_r        <= 8'h00;
            sample_cnt_r <= 16'd0;
        end else if (clear_i) begin
            if (avg_valid_i) begin
                min_r        <= avg_i;
                max_r        <= avg_i;
                sample_cnt_r <= 16'd1;
            end else begin
                min_r        <= 8'hFF;
                max_r        <= 8'h00;
                sample_cnt_r <= 16'd0;
            end
        end else if (avg_valid_i) begin
            min_r        <= (avg_i < min_r) ? avg_i : min_r;
            max_r        <= (avg_i > max_r) ? avg_i : max_r;
            sample_cnt_r <= (sample_cnt_r == 16'hFFFF) ? sample_cnt_r : (sample_cnt_r + 16'd1);
        end
    end

`ifdef AVG_MON_RATE_EN
    logic [7:0] prev_r;
    logic       has_prev_r;
    logic       rate_err_r;
    logic [8:0] diff_s;
    logic [8:0] abs_diff_s;
    logic       rate_viol_s;

    // Magnitude of the step from the previous accepted sample
    always_comb begin
        diff_s      = {1'b0, avg_i} - {1'b0, prev_r};
        abs_diff_s  = diff_s[8] ? (9'd0 - diff_s) : diff_s;
        rate_viol_s = has_prev_r && (abs_diff_s > {1'b0, RATE_MAX});
    end

    // Previous-sample tracking and sticky rate error
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_r     <= 8'd0;
            has_prev_r <= 1'b0;
            rate_err_r <= 1'b0;
        end else if (clear_i) begin
            // A sample arriving with clear starts a fresh history and is never rate-checked.
            rate_err_r <= 1'b0;
            has_prev_r <= avg_valid_i;
            prev_r     <= avg_valid_i ? avg_i : prev_r;
        end else if (avg_valid_i) begin
            rate_err_r <= rate_err_r | rate_viol_s;
            prev_r     <= avg_i;
            has_prev_r <= 1'b1;
        end
    end

    assign rate_err_o = rate_err_r;
`else
    logic unused_rate_s;
    assign unused_rate_s = ^RATE_MAX;
    assign rate_err_o    = 1'b0;
`endif

    assign alarm_hi_o   = alarm_hi_r;
    assign alarm_lo_o   = alarm_lo_r;
    assign irq_o        = irq_r;
    assign event_code_o = event_code_r;
    assign overrun_o    = overrun_r;
    assign min_o        = min_r;
    assign max_o        = max_r;
    assign sample_cnt_o = sample_cnt_r;

endmodule
